mem_port_scheduler: RTL and testbench
=====================================

# mem_port_scheduler

Sequences and shares the single-port data memory between the memory functional unit and the program loader/debug port. Loads and stores from the functional unit become memory cycles. Load results are broadcast on the CDB, and output instructions are routed to the transmit stream. The block sits between the memory functional unit's request port and the on-chip BRAM, and arbitrates round-robin against the loader.

## Interface
Parameters:
- ADDR_W, 12, BRAM word-address width; mem_addr = request address[ADDR_W-1:0], upper bits ignored (aliasing).
- DATA_W, CDB_W, RSV_ID_W, INSTR_W: taken from fcpu_pkg, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- a_valid  in  1  functional-unit request valid.
- a_opcode  in  INSTR_W  I_LOAD/I_LOADB = read; I_STORE/I_STOREB/I_STORER = write; I_OUTPUT = transmit; anything else = accept and drop.
- a_rsv_id  in  RSV_ID_W  tag for the load result.
- a_address  in  DATA_W  word address.
- a_data  in  DATA_W  store/output data.
- a_ready  out  1  request accepted when a_valid & a_ready.
- b_valid, b_we  in  1,1  loader request and write select.
- b_address, b_data  in  DATA_W  loader address and write data.
- b_ready  out  1  loader accepted.
- b_rdata  out  DATA_W  loader read data.
- b_rvalid  out  1  one-cycle pulse; b_rdata valid (no backpressure).
- o_cdb  out  CDB_W  {rsv_id, data}.
- o_cdb_valid  out  1  load result valid.
- o_cdb_ready  in  1  CDB accepts.
- tx_data  out  8  a_data[7:0] of I_OUTPUT.
- tx_valid  out  1  transmit valid.
- tx_ready  in  1  transmit accepts.
- mem_en, mem_we  out  1,1  BRAM enable and write.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data, valid exactly 1 cycle after mem_en & !mem_we.

## Operation
- FSM states: IDLE, READ, RESP, OUT.
- IDLE: exactly one of a_ready/b_ready may be 1, and only that requester is granted.
  - Grant rule: if only one requester is valid, it wins. If both are valid, the requester not granted last wins.
  - last_grant register resets to B, so A wins the first tie.
  - When no request is valid, a_ready = 1 and b_ready = 0 is permitted; tests must not depend on this.
- Accept cycle (combinational from the granted request): mem_en/mem_we/mem_addr/mem_wdata driven.
- Write (store or b_we): memory written at that edge; FSM stays in IDLE.
- Read from A: capture rsv_id and go to READ.
  - READ: latch {rsv_id, mem_rdata} into the o_cdb register and go to RESP.
  - RESP: o_cdb_valid = 1, held stable until o_cdb_ready, then return to IDLE.
- Read from B: go to READ; in READ, drive b_rdata = mem_rdata with b_rvalid = 1, then go to IDLE (never RESP).
- I_OUTPUT: no memory access; latch a_data[7:0] and go to OUT.
  - OUT: tx_valid = 1 until tx_ready, then return to IDLE.
- Unknown opcode: a_ready handshake completes, no memory, CDB or tx activity; FSM stays in IDLE.
- last_grant updates on every accepted handshake.
- No ready is asserted outside IDLE.

## Timing
- Reset values:
  - State IDLE, last_grant = B.
  - a_ready, b_ready, b_rvalid, o_cdb_valid, tx_valid, mem_en, mem_we = 0.
  - o_cdb, b_rdata, tx_data, mem_addr, mem_wdata = 0.
- rst in any state returns to IDLE on the next edge. Any in-flight load result or tx byte is discarded, not delivered.
- Store: 1 cycle; back-to-back stores sustain 1 per cycle.
- A-load: accept at cycle t, o_cdb_valid first high at t+2, next accept no earlier than t+3 (with o_cdb_ready = 1).
- B-load: accept at cycle t, b_rvalid at t+1, next accept at t+2.
- I_OUTPUT: accept at t, tx_valid at t+1, next accept at t+2 (with tx_ready = 1).
- While in RESP/OUT, stalled o_cdb_ready/tx_ready hold all outputs stable; b requests wait.
- o_cdb_valid, b_rvalid and tx_valid are never high together.

## Test plan
- Reset, then A store addr 0x10 data 0xDEADBEEF, then A I_LOAD addr 0x10 rsv_id 5 -> o_cdb = {5, 0xDEADBEEF} valid 2 cycles after the load accept, exactly one handshake.
- Alias: store 0x1234 to address 0x1010 (ADDR_W=12), load address 0x0010 -> returns 0x1234.
- A and B valid every cycle with stores -> grants alternate A,B,A,B starting with A; no cycle has both readys high.
- A load with o_cdb_ready low for 4 cycles -> o_cdb_valid held and o_cdb stable for 5 cycles; b_ready stays 0 throughout.
- A I_OUTPUT data 0x141 with tx_ready low 3 cycles -> tx_data = 0x41 held until tx_ready, mem_en never asserted.
- rst asserted while in RESP -> next cycle o_cdb_valid = 0, state IDLE, next tie grants A.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// rtl/mem_port_scheduler.sv - shares the single-port data BRAM between the memory FU and the loader port
//
// Purpose: grants the BRAM round-robin to the functional unit (A) and the
// loader/debug port (B). Loads from A return on the CDB, loads from B on
// b_rdata/b_rvalid, I_OUTPUT bytes go to the tx stream.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   a_valid/a_ready, a_*       functional-unit request (opcode, rsv_id, address, data)
//   b_valid/b_ready, b_*       loader request (we, address, data), b_rdata/b_rvalid read return
//   o_cdb/o_cdb_valid/_ready   load result {rsv_id, data}
//   tx_data/tx_valid/tx_ready  transmit byte stream
//   mem_*                      BRAM port, mem_rdata one cycle after a read enable

package fcpu_pkg;
  localparam int DATA_W   = 32;
  localparam int RSV_ID_W = 4;
  localparam int CDB_W    = RSV_ID_W + DATA_W;
  localparam int INSTR_W  = 6;

  localparam logic [INSTR_W-1:0] I_LOAD   = 6'd1;
  localparam logic [INSTR_W-1:0] I_LOADB  = 6'd2;
  localparam logic [INSTR_W-1:0] I_STORE  = 6'd3;
  localparam logic [INSTR_W-1:0] I_STOREB = 6'd4;
  localparam logic [INSTR_W-1:0] I_STORER = 6'd5;
  localparam logic [INSTR_W-1:0] I_OUTPUT = 6'd6;
endpackage

module mem_port_scheduler
  import fcpu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  input  logic [INSTR_W-1:0]  a_opcode,
  input  logic [RSV_ID_W-1:0] a_rsv_id,
  input  logic [DATA_W-1:0]   a_address,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_ready,
  input  logic                b_valid,
  input  logic                b_we,
  input  logic [DATA_W-1:0]   b_address,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_ready,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  output logic [CDB_W-1:0]    o_cdb,
  output logic                o_cdb_valid,
  input  logic                o_cdb_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, RESP, OUT} state_t;

  state_t              state_q, state_d;
  logic                last_b;   // 1 when B was granted most recently
  logic                rd_b;     // read in flight belongs to B
  logic [RSV_ID_W-1:0] rsv_q;
  logic [CDB_W-1:0]    cdb_q;
  logic [7:0]          tx_q;

  logic op_read, op_write, op_out;
  logic idle, grant_b, a_fire, b_fire;

  // Upper address bits alias onto the BRAM and are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{a_address[DATA_W-1:ADDR_W], b_address[DATA_W-1:ADDR_W]};

  always_comb begin
    op_read  = (a_opcode == I_LOAD) || (a_opcode == I_LOADB);
    op_write = (a_opcode == I_STORE) || (a_opcode == I_STOREB) || (a_opcode == I_STORER);
    op_out   = (a_opcode == I_OUTPUT);

    idle    = (state_q == IDLE) && !rst;
    // B wins when it is alone, or on a tie when A had the last grant.
    grant_b = b_valid && (!a_valid || !last_b);
    a_ready = idle && !grant_b;
    b_ready = idle && grant_b;
    a_fire  = a_valid && a_ready;
    b_fire  = b_valid && b_ready;

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_fire) begin
      mem_en    = op_read || op_write;
      mem_we    = op_write;
      mem_addr  = (op_read || op_write) ? a_address[ADDR_W-1:0] : '0;
      mem_wdata = op_write ? a_data : '0;
    end else if (b_fire) begin
      mem_en    = 1'b1;
      mem_we    = b_we;
      mem_addr  = b_address[ADDR_W-1:0];
      mem_wdata = b_we ? b_data : '0;
    end

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (a_fire && op_read)       state_d = READ;
        else if (a_fire && op_out)   state_d = OUT;
        else if (b_fire && !b_we)    state_d = READ;
      end
      READ:    state_d = rd_b ? IDLE : RESP;
      RESP:    if (o_cdb_ready) state_d = IDLE;
      OUT:     if (tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_b  <= 1'b1;
      rd_b    <= 1'b0;
      rsv_q   <= '0;
      cdb_q   <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      if (a_fire)      last_b <= 1'b0;
      else if (b_fire) last_b <= 1'b1;
      if (a_fire && op_read) begin
        rsv_q <= a_rsv_id;
        rd_b  <= 1'b0;
      end
      if (b_fire && !b_we) rd_b <= 1'b1;
      if (state_q == READ && !rd_b) cdb_q <= {rsv_q, mem_rdata};
      if (a_fire && op_out) tx_q <= a_data[7:0];
    end
  end

  assign o_cdb       = cdb_q;
  assign o_cdb_valid = (state_q == RESP);
  assign tx_data     = tx_q;
  assign tx_valid    = (state_q == OUT);
  assign b_rvalid    = (state_q == READ) && rd_b;
  // B read data passes straight through from the BRAM in its return cycle.
  assign b_rdata     = b_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// tb/tb_mem_port_scheduler.sv - scoreboard bench for mem_port_scheduler
module tb_mem_port_scheduler;
  import fcpu_pkg::*;

  localparam int ADDR_W = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic                a_valid, a_ready;
  logic [INSTR_W-1:0]  a_opcode;
  logic [RSV_ID_W-1:0] a_rsv_id;
  logic [DATA_W-1:0]   a_address, a_data;
  logic                b_valid, b_we, b_ready, b_rvalid;
  logic [DATA_W-1:0]   b_address, b_data, b_rdata;
  logic [CDB_W-1:0]    o_cdb;
  logic                o_cdb_valid, o_cdb_ready;
  logic [7:0]          tx_data;
  logic                tx_valid, tx_ready;
  logic                mem_en, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_port_scheduler #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_rsv_id(a_rsv_id),
    .a_address(a_address), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_we(b_we), .b_address(b_address), .b_data(b_data),
    .b_ready(b_ready), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .o_cdb(o_cdb), .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // BRAM environment model
  logic [DATA_W-1:0] bram [4096];
  initial for (int i = 0; i < 4096; i++) bram[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  // Reference model: word memory addressed by the low ADDR_W bits
  logic [DATA_W-1:0] ref_mem [int];
  logic [CDB_W-1:0]  cdb_q [$];
  logic [DATA_W-1:0] brd_q [$];
  logic [7:0]        tx_q  [$];
  bit                last_win_b = 1'b1;

  logic [INSTR_W-1:0] ops [8] = '{I_LOAD, I_LOADB, I_STORE, I_STOREB, I_STORER, I_OUTPUT, 6'h00, 6'h3F};

  function automatic logic [DATA_W-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Stimulus tracker: every accepted request pushes its expected response
  always @(negedge clk) begin
    int a;
    if (rst) begin
      last_win_b = 1'b1;
    end else begin
      chk("ready_exclusive", {63'd0, a_ready && b_ready}, 64'd0);
      if (a_valid && b_valid && (a_ready || b_ready))
        chk("tie_grant", {63'd0, a_ready}, {63'd0, last_win_b});
      if (a_valid && a_ready) begin
        a = int'(a_address % 4096);
        if (a_opcode == I_STORE || a_opcode == I_STOREB || a_opcode == I_STORER)
          ref_mem[a] = a_data;
        else if (a_opcode == I_LOAD || a_opcode == I_LOADB)
          cdb_q.push_back({a_rsv_id, ref_rd(a)});
        else if (a_opcode == I_OUTPUT)
          tx_q.push_back(a_data[7:0]);
        last_win_b = 1'b0;
      end
      if (b_valid && b_ready) begin
        a = int'(b_address % 4096);
        if (b_we) ref_mem[a] = b_data;
        else      brd_q.push_back(ref_rd(a));
        last_win_b = 1'b1;
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents a response
  bit               cdb_stall = 0, tx_stall = 0;
  logic [CDB_W-1:0] prev_cdb;
  logic [7:0]       prev_tx;
  always @(negedge clk) begin
    if (rst) begin
      cdb_stall = 0;
      tx_stall  = 0;
    end else begin
      chk("valids_exclusive", {62'd0, (o_cdb_valid + b_rvalid + tx_valid) > 2'd1}, 64'd0);
      if (o_cdb_valid || tx_valid || b_rvalid)
        chk("no_ready_busy", {62'd0, a_ready, b_ready}, 64'd0);
      if (tx_valid) chk("tx_no_mem", {63'd0, mem_en}, 64'd0);
      if (cdb_stall) chk("cdb_hold", {o_cdb_valid, o_cdb}, {1'b1, prev_cdb});
      if (tx_stall)  chk("tx_hold", {tx_valid, tx_data}, {1'b1, prev_tx});
      if (o_cdb_valid && o_cdb_ready) begin
        if (cdb_q.size() == 0) chk("cdb_unexpected", 64'd1, 64'd0);
        else chk("cdb_data", o_cdb, cdb_q.pop_front());
      end
      if (b_rvalid) begin
        if (brd_q.size() == 0) chk("brd_unexpected", 64'd1, 64'd0);
        else chk("b_rdata", b_rdata, brd_q.pop_front());
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) chk("tx_unexpected", 64'd1, 64'd0);
        else chk("tx_data", tx_data, tx_q.pop_front());
      end
      cdb_stall = o_cdb_valid && !o_cdb_ready;
      tx_stall  = tx_valid && !tx_ready;
      prev_cdb  = o_cdb;
      prev_tx   = tx_data;
    end
  end

  task automatic idle_inputs();
    a_valid = 0; a_opcode = '0; a_rsv_id = '0; a_address = '0; a_data = '0;
    b_valid = 0; b_we = 0; b_address = '0; b_data = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    cdb_q.delete(); brd_q.delete(); tx_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic a_issue(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] rsv,
                         input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
    bit got = 0;
    a_valid = 1; a_opcode = op; a_rsv_id = rsv; a_address = addr; a_data = data;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = a_ready;
      @(posedge clk); #1;
    end
    a_valid = 0;
    chk("a_accept", {63'd0, got}, 64'd1);
  endtask

  task automatic wait_cdb_valid();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = o_cdb_valid;
    end
    chk("cdb_valid_seen", {63'd0, seen}, 64'd1);
  endtask

  initial begin
    logic [CDB_W-1:0] c0;
    idle_inputs();
    o_cdb_ready = 1; tx_ready = 1; rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_readys", {62'd0, a_ready, b_ready}, 64'd0);
    chk("rst_valids", {61'd0, b_rvalid, o_cdb_valid, tx_valid}, 64'd0);
    chk("rst_mem_ctl", {62'd0, mem_en, mem_we}, 64'd0);
    chk("rst_o_cdb", o_cdb, 64'd0);
    chk("rst_b_rdata", b_rdata, 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    @(posedge clk); #1;
    rst = 0;

    // Store then A-load: result on CDB two cycles after accept, once
    a_issue(I_STORE, 0, 32'h10, 32'hDEADBEEF);
    a_issue(I_LOAD, 5, 32'h10, 32'h0);
    @(negedge clk);
    chk("load_t1_valid", {63'd0, o_cdb_valid}, 64'd0);
    @(negedge clk);
    chk("load_t2_valid", {63'd0, o_cdb_valid}, 64'd1);
    chk("load_t2_cdb", o_cdb, {4'd5, 32'hDEADBEEF});
    @(negedge clk);
    chk("load_t3_valid", {63'd0, o_cdb_valid}, 64'd0);
    @(posedge clk); #1;

    // Address aliasing above ADDR_W
    a_issue(I_STORE, 0, 32'h1010, 32'h1234);
    a_issue(I_LOAD, 3, 32'h0010, 32'h0);
    wait_cdb_valid();
    chk("alias_data", o_cdb, {4'd3, 32'h1234});
    @(posedge clk); #1;

    // B-load latency: b_rvalid the cycle after accept
    b_valid = 1; b_we = 0; b_address = 32'h10;
    @(negedge clk);
    chk("b_load_accept", {63'd0, b_ready}, 64'd1);
    @(posedge clk); #1;
    b_valid = 0;
    @(negedge clk);
    chk("b_load_rvalid", {63'd0, b_rvalid}, 64'd1);
    chk("b_load_rdata", b_rdata, 64'h1234);
    @(posedge clk); #1;

    // Tie on stores right after reset: A,B,A,B...
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a_valid = 1; a_opcode = I_STORE; a_address = 32'h200 + i; a_data = $urandom;
      b_valid = 1; b_we = 1; b_address = 32'h280 + i; b_data = $urandom;
      @(negedge clk);
      chk("alt_a_ready", {63'd0, a_ready}, {63'd0, (i % 2) == 0});
      chk("alt_b_ready", {63'd0, b_ready}, {63'd0, (i % 2) == 1});
      @(posedge clk); #1;
    end
    idle_inputs();

    // CDB stall: held 5 cycles, loader waits
    o_cdb_ready = 0;
    a_issue(I_LOAD, 7, 32'h205, 32'h0);
    b_valid = 1; b_we = 1; b_address = 32'h300; b_data = 32'hCAFE0001;
    wait_cdb_valid();
    c0 = o_cdb;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_valid", {63'd0, o_cdb_valid}, 64'd1);
      chk("stall_cdb", o_cdb, c0);
      chk("stall_b_ready", {63'd0, b_ready}, 64'd0);
      @(posedge clk); #1;
      if (i == 3) o_cdb_ready = 1;
    end
    @(negedge clk);
    chk("after_stall_b_ready", {63'd0, b_ready}, 64'd1);
    @(posedge clk); #1;
    b_valid = 0;

    // I_OUTPUT with tx backpressure
    tx_ready = 0;
    a_issue(I_OUTPUT, 0, 32'h555, 32'h141);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tx_valid", {63'd0, tx_valid}, 64'd1);
      chk("tx_byte", tx_data, 64'h41);
      chk("tx_mem_en", {63'd0, mem_en}, 64'd0);
      @(posedge clk); #1;
      if (i == 2) tx_ready = 1;
    end
    @(negedge clk);
    chk("tx_done", {63'd0, tx_valid}, 64'd0);
    @(posedge clk); #1;

    // Reset while in RESP discards the result; next tie goes to A
    a_issue(I_STORE, 0, 32'h1, 32'h1);
    o_cdb_ready = 0;
    a_issue(I_LOAD, 2, 32'h10, 32'h0);
    wait_cdb_valid();
    @(posedge clk); #1;
    rst = 1;
    cdb_q.delete(); brd_q.delete(); tx_q.delete();
    @(posedge clk); #1;
    rst = 0;
    o_cdb_ready = 1;
    a_valid = 1; a_opcode = I_STORE; a_address = 32'h40; a_data = 32'h77;
    b_valid = 1; b_we = 1; b_address = 32'h41; b_data = 32'h88;
    @(negedge clk);
    chk("rst_resp_valid", {63'd0, o_cdb_valid}, 64'd0);
    chk("rst_resp_tie", {62'd0, a_ready, b_ready}, 64'd2);
    @(posedge clk); #1;
    idle_inputs();

    // Randomized traffic against the scoreboard
    for (int n = 0; n < 1500; n++) begin
      a_valid   = ($urandom % 2) == 1;
      a_opcode  = ops[$urandom % 8];
      a_rsv_id  = RSV_ID_W'($urandom);
      a_address = ($urandom_range(0, 3) << 12) | $urandom_range(0, 15);
      a_data    = $urandom;
      b_valid   = ($urandom % 2) == 1;
      b_we      = ($urandom % 2) == 1;
      b_address = ($urandom_range(0, 3) << 12) | $urandom_range(0, 15);
      b_data    = $urandom;
      o_cdb_ready = ($urandom % 4) != 0;
      tx_ready    = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    idle_inputs();
    o_cdb_ready = 1; tx_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_cdb", cdb_q.size(), 64'd0);
    chk("drain_brd", brd_q.size(), 64'd0);
    chk("drain_tx", tx_q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
